// File: rtl/dram_refresh_scheduler_if.sv
// Refresh scheduler bus: Zorro II / access-controller status in, refresh strobes and backlog status out.
interface dram_refresh_scheduler_if;
    logic       ASn;
    logic       ACCESS_ACTIVE;
    logic       REF_CASn;
    logic       REF_RASn;
    logic       REF_BUSY;
    logic       REF_URGENT;
    logic [3:0] REF_PENDING;
    logic       OVERRUN;

    modport master (
        input  ASn,
        input  ACCESS_ACTIVE,
        output REF_CASn,
        output REF_RASn,
        output REF_BUSY,
        output REF_URGENT,
        output REF_PENDING,
        output OVERRUN
    );

    modport slave (
        output ASn,
        output ACCESS_ACTIVE,
        input  REF_CASn,
        input  REF_RASn,
        input  REF_BUSY,
        input  REF_URGENT,
        input  REF_PENDING,
        input  OVERRUN
    );
endinterface

// File: rtl/dram_refresh_scheduler.sv
// CAS-before-RAS refresh scheduler for the FastRAM array; backlogs refresh ticks while the
// Zorro II bus is busy and issues them back-to-back once it goes idle.
module dram_refresh_scheduler #(
    parameter int unsigned INTERVAL    = 108,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned CAS_CYCLES  = 1,
    parameter int unsigned RAS_CYCLES  = 2,
    parameter int unsigned PRE_CYCLES  = 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    dram_refresh_scheduler_if.master         bus
);

    localparam int unsigned CNT_W  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int unsigned PEND_W = 4;
    localparam int unsigned PH_MAX0 = (CAS_CYCLES > RAS_CYCLES) ? CAS_CYCLES : RAS_CYCLES;
    localparam int unsigned PH_MAX  = (PH_MAX0 > PRE_CYCLES) ? PH_MAX0 : PRE_CYCLES;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INTERVAL - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PH_W-1:0]   CAS_LOAD = PH_W'(CAS_CYCLES - 1);
    localparam logic [PH_W-1:0]   RAS_LOAD = PH_W'(RAS_CYCLES - 1);
    localparam logic [PH_W-1:0]   PRE_LOAD = PH_W'(PRE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAS,
        ST_RAS,
        ST_PRE
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              as_meta_q, as_meta_d;
    logic              as_idle_q, as_idle_d;
    logic              urgent_q, urgent_d;
    logic              overrun_q, overrun_d;
    logic              cas_n_q, cas_n_d;
    logic              ras_n_q, ras_n_d;
    logic              busy_q, busy_d;
    logic              tick_c;
    logic              issue_c;

    // Two-flop synchroniser for the asynchronous address strobe; high means bus idle.
    always_comb begin
        as_meta_d = bus.ASn;
        as_idle_d = as_meta_q;
    end

    // Interval counter; the tick and the wrap share the same edge.
    always_comb begin
        tick_c = (cnt_q == CNT_LAST);
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    assign issue_c = (state_q == ST_IDLE) && (pend_q != '0) && as_idle_q && !bus.ACCESS_ACTIVE;

    // Backlog: a coincident tick and issue cancel out; a tick at saturation flags an overrun.
    always_comb begin
        pend_d    = pend_q;
        overrun_d = overrun_q;
        if (tick_c && !issue_c) begin
            if (pend_q >= PEND_MAX) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (issue_c && !tick_c) begin
            pend_d = pend_q - PEND_W'(1);
        end
        urgent_d = (pend_d == PEND_MAX);
    end

    // Sequence FSM; the phase counter is reloaded on every state entry and counts down to zero.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    state_d = ST_CAS;
                    phase_d = CAS_LOAD;
                end
            end
            ST_CAS: begin
                if (phase_q == '0) begin
                    state_d = ST_RAS;
                    phase_d = RAS_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_RAS: begin
                if (phase_q == '0) begin
                    state_d = ST_PRE;
                    phase_d = PRE_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_PRE: begin
                if (phase_q == '0) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_comb begin
        cas_n_d = !((state_d == ST_CAS) || (state_d == ST_RAS));
        ras_n_d = (state_d != ST_RAS);
        busy_d  = (state_d != ST_IDLE);
    end

    // Asynchronous reset releases both strobes immediately, even mid-sequence.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            as_meta_q <= 1'b1;
            as_idle_q <= 1'b1;
            urgent_q  <= 1'b0;
            overrun_q <= 1'b0;
            cas_n_q   <= 1'b1;
            ras_n_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            as_meta_q <= as_meta_d;
            as_idle_q <= as_idle_d;
            urgent_q  <= urgent_d;
            overrun_q <= overrun_d;
            cas_n_q   <= cas_n_d;
            ras_n_q   <= ras_n_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.REF_CASn    = cas_n_q;
    assign bus.REF_RASn    = ras_n_q;
    assign bus.REF_BUSY    = busy_q;
    assign bus.REF_URGENT  = urgent_q;
    assign bus.REF_PENDING = pend_q;
    assign bus.OVERRUN     = overrun_q;

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Scoreboard bench for dram_refresh_scheduler: timed expectations are queued by the stimulus
// and checked by an independent monitor on the falling clock edge.
module tb_dram_refresh_scheduler;

    localparam int F_CAS  = 0;
    localparam int F_RAS  = 1;
    localparam int F_BUSY = 2;
    localparam int F_URG  = 3;
    localparam int F_PEND = 4;
    localparam int F_OVR  = 5;

    typedef struct {
        int cyc;
        int fld;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    dram_refresh_scheduler_if bus ();

    dram_refresh_scheduler dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int get_fld(int f);
        case (f)
            F_CAS:   return int'(bus.REF_CASn);
            F_RAS:   return int'(bus.REF_RASn);
            F_BUSY:  return int'(bus.REF_BUSY);
            F_URG:   return int'(bus.REF_URGENT);
            F_PEND:  return int'(bus.REF_PENDING);
            default: return int'(bus.OVERRUN);
        endcase
    endfunction

    function automatic string fld_name(int f);
        case (f)
            F_CAS:   return "REF_CASn";
            F_RAS:   return "REF_RASn";
            F_BUSY:  return "REF_BUSY";
            F_URG:   return "REF_URGENT";
            F_PEND:  return "REF_PENDING";
            default: return "OVERRUN";
        endcase
    endfunction

    // Monitor: pops every expectation that is due at this cycle and compares it.
    exp_t mon_e;
    int   mon_act;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = get_fld(mon_e.fld);
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s stale expectation for cycle %0d seen at %0d", fld_name(mon_e.fld), mon_e.cyc, cyc);
            end else if (mon_act != mon_e.val) begin
                errors++;
                $display("FAIL %s at cycle %0d: got %0d expected %0d", fld_name(mon_e.fld), cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic ex(input int c, input int f, input int v);
        exp_t e;
        e.cyc = c;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reset values, then the first refresh on an idle bus.
    task automatic exp_first(input int b);
        ex(b+1, F_CAS, 1); ex(b+1, F_RAS, 1); ex(b+1, F_BUSY, 0);
        ex(b+1, F_URG, 0); ex(b+1, F_PEND, 0); ex(b+1, F_OVR, 0);
        ex(b+107, F_PEND, 0);
        ex(b+108, F_PEND, 1); ex(b+108, F_CAS, 1);
        ex(b+109, F_CAS, 0); ex(b+109, F_PEND, 0); ex(b+109, F_BUSY, 1); ex(b+109, F_RAS, 1);
        ex(b+110, F_RAS, 0); ex(b+110, F_CAS, 0);
        ex(b+111, F_RAS, 0); ex(b+111, F_CAS, 0);
        ex(b+112, F_RAS, 1); ex(b+112, F_CAS, 1); ex(b+112, F_BUSY, 1);
        ex(b+113, F_BUSY, 0);
    endtask

    task automatic exp_rest(input int b);
        // Five-interval backlog, then back-to-back drain 5 clocks apart.
        ex(b+216, F_PEND, 1); ex(b+324, F_PEND, 2);
        ex(b+400, F_CAS, 1); ex(b+400, F_RAS, 1); ex(b+400, F_BUSY, 0);
        ex(b+432, F_PEND, 3); ex(b+540, F_PEND, 4); ex(b+648, F_PEND, 5);
        ex(b+650, F_CAS, 1); ex(b+650, F_BUSY, 0);
        ex(b+655, F_BUSY, 0); ex(b+655, F_PEND, 5);
        ex(b+656, F_CAS, 0); ex(b+656, F_PEND, 4);
        ex(b+657, F_RAS, 0); ex(b+657, F_CAS, 0);
        ex(b+658, F_RAS, 0);
        ex(b+659, F_RAS, 1); ex(b+659, F_CAS, 1); ex(b+659, F_BUSY, 1);
        ex(b+660, F_BUSY, 0);
        ex(b+661, F_CAS, 0); ex(b+661, F_PEND, 3);
        ex(b+666, F_PEND, 2); ex(b+671, F_PEND, 1);
        ex(b+676, F_PEND, 0); ex(b+676, F_CAS, 0);
        ex(b+680, F_BUSY, 0);
        // Ten-interval backlog: saturation, urgent, sticky overrun.
        ex(b+756, F_PEND, 1);
        ex(b+1404, F_PEND, 7); ex(b+1404, F_URG, 0);
        ex(b+1512, F_PEND, 8); ex(b+1512, F_URG, 1); ex(b+1512, F_OVR, 0);
        ex(b+1620, F_PEND, 8); ex(b+1620, F_OVR, 1); ex(b+1620, F_URG, 1);
        ex(b+1728, F_PEND, 8); ex(b+1728, F_OVR, 1);
        ex(b+1762, F_CAS, 1);
        ex(b+1763, F_PEND, 7); ex(b+1763, F_URG, 0); ex(b+1763, F_CAS, 0);
        ex(b+1798, F_PEND, 0); ex(b+1798, F_CAS, 0);
        ex(b+1800, F_OVR, 1);
        // Tick coincident with the first issue edge.
        ex(b+1836, F_PEND, 1);
        ex(b+1837, F_CAS, 0); ex(b+1837, F_PEND, 0);
        ex(b+1841, F_BUSY, 0);
        ex(b+2052, F_PEND, 2);
        ex(b+2159, F_PEND, 2); ex(b+2159, F_CAS, 1);
        ex(b+2160, F_PEND, 2); ex(b+2160, F_CAS, 0);
        ex(b+2165, F_PEND, 1); ex(b+2165, F_CAS, 0);
        ex(b+2170, F_PEND, 0);
        ex(b+2174, F_BUSY, 0);
        // ASn falls during RAS: sequence completes unchanged.
        ex(b+2268, F_PEND, 1); ex(b+2268, F_CAS, 1);
        ex(b+2269, F_CAS, 0); ex(b+2269, F_RAS, 1); ex(b+2269, F_BUSY, 1); ex(b+2269, F_PEND, 0);
        ex(b+2270, F_RAS, 0); ex(b+2270, F_CAS, 0); ex(b+2270, F_BUSY, 1);
        ex(b+2271, F_RAS, 0); ex(b+2271, F_CAS, 0); ex(b+2271, F_BUSY, 1);
        ex(b+2272, F_RAS, 1); ex(b+2272, F_CAS, 1); ex(b+2272, F_BUSY, 1);
        ex(b+2273, F_BUSY, 0); ex(b+2273, F_CAS, 1);
        // Reset asserted while RAS is low releases strobes at once.
        ex(b+2376, F_PEND, 1);
        ex(b+2377, F_CAS, 0);
        ex(b+2378, F_RAS, 0); ex(b+2378, F_OVR, 1);
        ex(b+2379, F_CAS, 1); ex(b+2379, F_RAS, 1); ex(b+2379, F_BUSY, 0);
        ex(b+2379, F_PEND, 0); ex(b+2379, F_OVR, 0); ex(b+2379, F_URG, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int b;
    int b2;
    initial begin
        bus.ASn           = 1'b1;
        bus.ACCESS_ACTIVE = 1'b0;
        rst               = 1'b1;
        repeat (3) @(negedge clk);
        b = cyc;
        exp_first(b);
        exp_rest(b);
        rst = 1'b0;

        wait_cyc(b+113);  bus.ASn = 1'b0;
        wait_cyc(b+653);  bus.ASn = 1'b1;
        wait_cyc(b+680);  bus.ASn = 1'b0;
        wait_cyc(b+1760); bus.ASn = 1'b1;
        wait_cyc(b+1841); bus.ASn = 1'b0;
        wait_cyc(b+2157); bus.ASn = 1'b1;
        wait_cyc(b+2270); bus.ASn = 1'b0;
        wait_cyc(b+2274); bus.ASn = 1'b1;

        wait_cyc(b+2378);
        @(posedge clk);
        #2 rst = 1'b1;
        wait_cyc(b+2382);
        b2 = cyc;
        exp_first(b2);
        // ACCESS_ACTIVE holds off the issue until it drops.
        ex(b2+216, F_PEND, 1); ex(b2+216, F_CAS, 1);
        ex(b2+219, F_PEND, 1); ex(b2+219, F_CAS, 1);
        ex(b2+220, F_PEND, 0); ex(b2+220, F_CAS, 0);
        ex(b2+224, F_BUSY, 0);
        rst = 1'b0;

        wait_cyc(b2+200); bus.ACCESS_ACTIVE = 1'b1;
        wait_cyc(b2+219); bus.ACCESS_ACTIVE = 1'b0;

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never reached, expected 0", sb.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_refresh_scheduler.md
Name: dram_refresh_scheduler

Overview:
- Generates timed CAS-before-RAS refresh requests for the 8MB FastRAM DRAM array.
- Sits directly upstream of the DRAM access controller. It produces the refresh CAS/RAS strobes that the controller ORs into RAS1n–RAS4n, UCASn and LCASn, and a busy flag that holds off new RAM cycles.
- Refresh intervals that elapse while the Zorro II bus is active are backlogged, then issued back-to-back once the bus goes idle.

Parameters:
- INTERVAL, 108: CLK cycles per refresh tick (15.2 µs at 7.09 MHz).
- MAX_PENDING, 8: backlog saturation value; must be between 1 and 15.
- CAS_CYCLES, 1: clocks CAS is held alone before RAS (tCSR); must be ≥1.
- RAS_CYCLES, 2: clocks RAS and CAS are held together; must be ≥1.
- PRE_CYCLES, 1: precharge clocks with both strobes high; must be ≥1.

Ports:
- CLK  in  1  bus-derived clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ASn  in  1  Zorro II address strobe, asynchronous to CLK.
- ACCESS_ACTIVE  in  1  high while the access controller is driving an access RAS/CAS.
- REF_CASn  out  1  refresh CAS, active low, registered.
- REF_RASn  out  1  refresh RAS, active low, registered.
- REF_BUSY  out  1  high while a refresh sequence is in progress; the access controller must not start ram_cycle while it is high.
- REF_URGENT  out  1  high when the backlog equals MAX_PENDING.
- REF_PENDING  out  4  current backlog count.
- OVERRUN  out  1  sticky; set when a tick arrives with the backlog already saturated.

Behaviour:
- Reset: decided fact — one clock (CLK); reset RESET is asynchronous and active-high.
  - Reset values: REF_CASn=1, REF_RASn=1, REF_BUSY=0, REF_URGENT=0, REF_PENDING=0, OVERRUN=0.
  - Internal reset values: interval counter=0, state=IDLE, ASn synchroniser flops=1.
  - Assertion mid-sequence releases both strobes immediately (asynchronously).
- ASn synchroniser: two flops. as_idle = second flop output (high means bus idle).
- Interval counter:
  - Range 0..INTERVAL-1; wraps to 0 after INTERVAL-1.
  - tick = counter at INTERVAL-1; it takes effect on the same edge the counter wraps.
- Backlog (REF_PENDING), evaluated each edge:
  - tick and no issue: +1, saturating at MAX_PENDING.
  - issue and no tick: -1.
  - tick and issue together: unchanged.
  - tick while already at MAX_PENDING with no issue: count stays, OVERRUN←1.
  - OVERRUN clears only on RESET.
- issue = (state==IDLE) & (REF_PENDING≠0) & as_idle & !ACCESS_ACTIVE.
- REF_URGENT is registered and equals (REF_PENDING==MAX_PENDING) as of the same edge.
- State machine (one phase counter, reloaded on each state entry):
  - IDLE → CAS on issue.
  - CAS → RAS after CAS_CYCLES clocks.
  - RAS → PRE after RAS_CYCLES clocks.
  - PRE → IDLE after PRE_CYCLES clocks.
  - No IDLE→CAS transition is possible on the same edge PRE exits; each sequence therefore has a minimum period of CAS+RAS+PRE+1 clocks.
- Outputs registered from the next state:
  - REF_CASn=0 in CAS and RAS.
  - REF_RASn=0 in RAS only.
  - REF_BUSY=1 in CAS, RAS and PRE.
- A started sequence always completes; ASn falling or ACCESS_ACTIVE rising mid-sequence has no effect on it.
- ACCESS_ACTIVE and REF_BUSY are never both asserted by construction. If both are sampled high, behaviour is unchanged; this is a verification assertion only.
- Latency: a tick on an idle bus asserts REF_CASn exactly 1 clock after REF_PENDING becomes nonzero.

Test Plan:
- Reset release, ASn=1, ACCESS_ACTIVE=0:
  - REF_PENDING=1 after edge 108.
  - REF_CASn low after edge 109, when REF_PENDING returns to 0.
  - REF_RASn low after edges 110–111; both strobes high after edge 112; REF_BUSY=0 after edge 113.
- ASn=0 held for 5×INTERVAL clocks:
  - REF_PENDING counts 1..5 and no strobes toggle.
  - On ASn=1, five sequences run back-to-back, each 5 clocks apart, and REF_PENDING decrements to 0.
- ASn=0 held for 10×INTERVAL clocks:
  - REF_PENDING saturates at 8; REF_URGENT=1.
  - OVERRUN=1 at the 9th tick and stays set after the backlog drains.
- Tick coincident with an issue edge (pending=2, bus goes idle on a tick edge): REF_PENDING stays 2 on that edge.
- ASn falls during RAS phase: sequence completes with exact CAS/RAS/PRE widths; REF_BUSY stays high throughout.
- RESET pulsed while REF_RASn=0:
  - Both strobes high immediately; REF_PENDING=0 and OVERRUN=0.
  - First refresh then follows the first scenario's timing.
